// File: rtl/mfu_slice_seq.sv
// Slice sequencer and shift-accumulator feeding one 2b x 2b mBB multiplier.
// Optional macro MFU_SEQ_ZERO_SKIP_EN: bypass RUN when a used operand is all zero.
module mfu_slice_seq #(
    parameter int DW = 8,
    parameter int PW = 2 * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic          a_signed,
    input  logic          b_signed,
    input  logic [1:0]    prec,
    output logic          mbb_en,
    output logic [1:0]    mbb_a,
    output logic [1:0]    mbb_b,
    output logic [1:0]    mbb_sel,
    input  logic [3:0]    mbb_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_p
);

    localparam int CW = (DW > 2) ? $clog2(DW / 2) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_P2 = '0;
    localparam logic [CW-1:0] LAST_P4 = CW'((DW >= 4) ? 1 : 0);
    localparam logic [CW-1:0] LAST_P8 = CW'(DW / 2 - 1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_a_signed;
    logic          r_b_signed;
    logic [CW-1:0] r_last;
    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [PW-1:0] r_acc;

    logic [CW-1:0] w_in_last;
    logic [CW:0]   w_a_idx;
    logic [CW:0]   w_b_idx;
    logic [CW:0]   w_ij_sum;
    logic [CW+1:0] w_shamt;
    logic [PW-1:0] w_pp_ext;
    logic          w_i_last;
    logic          w_j_last;

    // Slice index N-1 for the incoming precision; 11 behaves as full width.
    always_comb begin
        // NOTE: default first so every path assigns w_in_last and no latch is inferred.
        w_in_last = LAST_P8;
        case (prec)
            2'b00:   w_in_last = LAST_P2;
            2'b01:   w_in_last = LAST_P4;
            default: w_in_last = LAST_P8;
        endcase
    end

`ifdef MFU_SEQ_ZERO_SKIP_EN
    logic [CW:0]   w_in_n;
    logic [DW-1:0] w_used_mask;
    logic          w_in_zero;

    assign w_in_n      = {1'b0, w_in_last} + {{CW{1'b0}}, 1'b1};
    assign w_used_mask = ~({DW{1'b1}} << {w_in_n, 1'b0});
    assign w_in_zero   = ((a_in & w_used_mask) == '0) || ((b_in & w_used_mask) == '0);
`endif

    // mBB drive comes only from registered operands and counters, so DONE holds the last slice.
    assign w_i_last = (r_i == r_last);
    assign w_j_last = (r_j == r_last);
    assign w_a_idx  = {r_i, 1'b0};
    assign w_b_idx  = {r_j, 1'b0};
    assign mbb_a    = r_a[w_a_idx +: 2];
    assign mbb_b    = r_b[w_b_idx +: 2];
    assign mbb_sel  = {r_a_signed && w_i_last, r_b_signed && w_j_last};
    assign mbb_en   = (r_state == S_RUN);

    // Any signed slice makes the 4-bit partial product two's complement.
    assign w_pp_ext = (mbb_sel != 2'b00) ? {{(PW-4){mbb_p[3]}}, mbb_p}
                                         : {{(PW-4){1'b0}}, mbb_p};
    assign w_ij_sum = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt  = {w_ij_sum, 1'b0};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_p     = r_acc;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_a_signed <= 1'b0;
            r_b_signed <= 1'b0;
            r_last     <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_acc      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a_in;
                        r_b        <= b_in;
                        r_a_signed <= a_signed;
                        r_b_signed <= b_signed;
                        r_last     <= w_in_last;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_acc      <= '0;
`ifdef MFU_SEQ_ZERO_SKIP_EN
                        r_state    <= w_in_zero ? S_DONE : S_RUN;
`else
                        r_state    <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_acc <= r_acc + (w_pp_ext << w_shamt);
                    // j is the inner index; counters freeze on the final pair.
                    if (w_j_last) begin
                        if (w_i_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfu_slice_seq.sv
// Scoreboard bench for mfu_slice_seq with a behavioural 2b x 2b mBB model.
module tb_mfu_slice_seq;

    localparam int DW = 8;
    localparam int PW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          a_signed;
    logic          b_signed;
    logic [1:0]    prec;
    logic          mbb_en;
    logic [1:0]    mbb_a;
    logic [1:0]    mbb_b;
    logic [1:0]    mbb_sel;
    logic [3:0]    mbb_p;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] sb[$];

    always #5 clk = ~clk;

    mfu_slice_seq #(.DW(DW), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .prec     (prec),
        .mbb_en   (mbb_en),
        .mbb_a    (mbb_a),
        .mbb_b    (mbb_b),
        .mbb_sel  (mbb_sel),
        .mbb_p    (mbb_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p)
    );

    // mBB model; drives junk while disabled, which the sequencer must ignore.
    logic [3:0]        m_ea;
    logic [3:0]        m_eb;
    logic signed [7:0] m_prod;
    always_comb begin
        m_ea   = mbb_sel[1] ? {{2{mbb_a[1]}}, mbb_a} : {2'b00, mbb_a};
        m_eb   = mbb_sel[0] ? {{2{mbb_b[1]}}, mbb_b} : {2'b00, mbb_b};
        m_prod = $signed(m_ea) * $signed(m_eb);
        mbb_p  = mbb_en ? m_prod[3:0] : 4'hA;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic as, input logic bs, input int n);
        longint w;
        longint m;
        longint va;
        longint vb;
        longint p;
        w  = 2 * n;
        m  = (longint'(1) << w) - 1;
        va = longint'(a) & m;
        vb = longint'(b) & m;
        if (as && (((va >> (w - 1)) & 1) == 1)) va = va - (longint'(1) << w);
        if (bs && (((vb >> (w - 1)) & 1) == 1)) vb = vb - (longint'(1) << w);
        p = va * vb;
        return p[PW-1:0];
    endfunction

    task automatic run_job(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic as,
                           input logic bs, input logic [1:0] pr, input int hold);
        int n;
        int run;
        int ii;
        int jj;
        logic [PW-1:0] expv;
        logic [PW-1:0] popped;
        n    = (pr == 2'b00) ? 1 : (pr == 2'b01) ? 2 : 4;
        expv = model(a, b, as, bs, n);
        run  = n * n;
`ifdef MFU_SEQ_ZERO_SKIP_EN
        begin
            logic [DW-1:0] mask;
            mask = DW'((longint'(1) << (2 * n)) - 1);
            if (((a & mask) == '0) || ((b & mask) == '0)) run = 0;
        end
`endif
        @(negedge clk);
        check("in_ready idle", in_ready, 1);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        a_signed = as;
        b_signed = bs;
        prec     = pr;
        @(posedge clk);
        sb.push_back(expv);
        #1;
        in_valid = 1'b0;
        a_in     = ~a;
        b_in     = ~b;
        a_signed = ~as;
        b_signed = ~bs;
        prec     = ~pr;
        for (int k = 0; k < run; k++) begin
            @(negedge clk);
            ii = k / n;
            jj = k % n;
            check("mbb_en run", mbb_en, 1);
            check("mbb_a slice", mbb_a, (a >> (2 * ii)) & 8'h03);
            check("mbb_b slice", mbb_b, (b >> (2 * jj)) & 8'h03);
            check("mbb_sel", mbb_sel, {as && (ii == n - 1), bs && (jj == n - 1)});
            check("in_ready run", in_ready, 0);
            check("out_valid run", out_valid, 0);
            in_valid = (k == 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("out_valid done", out_valid, 1);
        check("mbb_en done", mbb_en, 0);
        for (int h = 0; h < hold; h++) begin
            check("out_p hold", out_p, expv);
            check("out_valid hold", out_valid, 1);
            check("in_ready hold", in_ready, 0);
            in_valid = (h == 1) && (hold >= 3);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("sb not empty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            popped = sb.pop_front();
            check("out_p", out_p, popped);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid drop", out_valid, 0);
        check("in_ready back", in_ready, 1);
        check("mbb_en idle", mbb_en, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_p"}, out_p, 0);
        check({tag, " mbb_en"}, mbb_en, 0);
        check({tag, " mbb_a"}, mbb_a, 0);
        check({tag, " mbb_b"}, mbb_b, 0);
        check({tag, " mbb_sel"}, mbb_sel, 0);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        check("in_ready pre-rst job", in_ready, 1);
        in_valid = 1'b1;
        a_in     = 8'h9C;
        b_in     = 8'h37;
        a_signed = 1'b1;
        b_signed = 1'b1;
        prec     = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mbb_en cycle7", mbb_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid-run rst");
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("no out_valid after rst", out_valid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        prec      = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        run_job(8'd200, 8'd150, 1'b0, 1'b0, 2'b10, 0);
        run_job(8'h80, 8'h7F, 1'b1, 1'b1, 2'b10, 0);
        run_job(8'hFD, 8'hF5, 1'b1, 1'b1, 2'b01, 0);
        run_job(8'hFE, 8'h02, 1'b1, 1'b1, 2'b00, 0);
        run_job(8'h35, 8'hC7, 1'b1, 1'b0, 2'b11, 5);
        reset_mid_run();
        run_job(8'hE3, 8'h19, 1'b0, 1'b1, 2'b10, 0);
        run_job(8'h00, 8'h6B, 1'b0, 1'b0, 2'b10, 0);
        run_job(8'hF0, 8'h03, 1'b1, 1'b0, 2'b01, 2);
        for (int r = 0; r < 8; r++) begin
            run_job(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        check("sb drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
